// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Buffers an N x N matrix pair (A, B) delivered one beat at a time, then
// streams them skewed into the west and north edges of an N x N systolic
// multiply-accumulate array.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   load_valid  load beat offered
//   load_ready  feeder accepts a load beat this cycle
//   load_a      beat k: A[i][k] in slice i (bits i*W +: W)
//   load_b      beat k: B[k][j] in slice j
//   start       begin a matrix-multiply pass (honoured only once loaded)
//   clear_n     active-low accumulator clear to the array
//   west_out    slice i feeds the west input of row i, column 0
//   north_out   slice j feeds the north input of column j, row 0
//   busy        pass in progress (CLEAR and STREAM)
//   done        one-cycle pulse once every PE accumulator is final
//
// Every output is a register loaded from the next-state values, so an output
// changes on the same edge the state it belongs to is entered.
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_valid,
  output logic           load_ready,
  input  logic [N*W-1:0] load_a,
  input  logic [N*W-1:0] load_b,
  input  logic           start,
  output logic           clear_n,
  output logic [N*W-1:0] west_out,
  output logic [N*W-1:0] north_out,
  output logic           busy,
  output logic           done
);

  localparam int CW     = $clog2(N + 1);  // beat counter, counts 0..N
  localparam int KW     = $clog2(N);      // buffer index
  localparam int TW     = $clog2(3 * N);  // stream index, 0..3N-3
  localparam int T_LAST = 3 * N - 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADED,
    ST_CLEAR,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [CW-1:0]  r_beat;
  logic [CW-1:0]  w_beat_next;
  logic [TW-1:0]  r_t;
  logic [TW-1:0]  w_t_next;

  // r_a[i][k] = A[i][k], r_b[k][j] = B[k][j]
  logic [W-1:0]   r_a [N][N];
  logic [W-1:0]   r_b [N][N];

  logic           w_accept;
  logic [KW-1:0]  w_widx;

  logic           r_load_ready;
  logic           r_clear_n;
  logic           r_busy;
  logic           r_done;
  logic [N*W-1:0] r_west;
  logic [N*W-1:0] r_north;
  logic [N*W-1:0] w_west_next;
  logic [N*W-1:0] w_north_next;

  // In IDLE the beat counter never exceeds N-1, so its low bits address
  // the buffer column/row directly.
  assign w_accept = (r_state == ST_IDLE) && load_valid;
  assign w_widx   = r_beat[KW-1:0];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_t_next     = r_t;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_beat_next = r_beat + CW'(1);
          if (r_beat == CW'(N - 1)) begin
            w_state_next = ST_LOADED;
          end
        end
      end
      ST_LOADED: begin
        if (start) begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_next = ST_STREAM;
        w_t_next     = '0;
      end
      ST_STREAM: begin
        if (r_t == TW'(T_LAST)) begin
          w_state_next = ST_DONE;
        end else begin
          w_t_next = r_t + TW'(1);
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_beat_next  = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_beat_next  = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Skewed output selection for the upcoming stream index. Row i and column i
  // share the same window: element index d = t - i is live for 0 <= d <= N-1,
  // giving A[i][d] on the west edge and B[d][i] on the north edge. Outside
  // the window the edge carries +0.0 so the PE multiplies to zero.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [TW-1:0] w_d;
    logic          w_live;

    assign w_d    = w_t_next - TW'(gi);
    assign w_live = (w_state_next == ST_STREAM) &&
                    (w_t_next >= TW'(gi)) && (w_d < TW'(N));

    assign w_west_next[gi*W +: W]  = w_live ? r_a[gi][w_d[KW-1:0]] : '0;
    assign w_north_next[gi*W +: W] = w_live ? r_b[w_d[KW-1:0]][gi] : '0;
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_t          <= '0;
      r_load_ready <= 1'b1;
      r_clear_n    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_west       <= '0;
      r_north      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_beat       <= w_beat_next;
      r_t          <= w_t_next;
      r_load_ready <= (w_state_next == ST_IDLE);
      r_clear_n    <= (w_state_next != ST_CLEAR);
      r_busy       <= (w_state_next == ST_CLEAR) || (w_state_next == ST_STREAM);
      r_done       <= (w_state_next == ST_DONE);
      r_west       <= w_west_next;
      r_north      <= w_north_next;
    end
  end

  // -------------------------------------------------------------------------
  // Operand buffers. Contents persist across passes; each new beat overwrites
  // one A column and one B row.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < N; i++) begin
        r_a[i][w_widx] <= load_a[i*W +: W];
        r_b[w_widx][i] <= load_b[i*W +: W];
      end
    end
  end

  assign load_ready = r_load_ready;
  assign clear_n    = r_clear_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign west_out   = r_west;
  assign north_out  = r_north;

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Drives systolic_feeder (N=4) with table-driven handshake vectors, fixed
// matrix cases and randomized integer-valued matrices. Expected edge streams
// come from placing A[i][k] / B[k][j] at stream step i+k / j+k; a
// behavioural N x N PE array fed from the DUT edges checks the final
// products against a direct integer matrix multiply.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NS = 3 * N - 2;

  logic           clk;
  logic           reset;
  logic           load_valid;
  logic           load_ready;
  logic [N*W-1:0] load_a;
  logic [N*W-1:0] load_b;
  logic           start;
  logic           clear_n;
  logic [N*W-1:0] west_out;
  logic [N*W-1:0] north_out;
  logic           busy;
  logic           done;

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_a     (load_a),
    .load_b     (load_b),
    .start      (start),
    .clear_n    (clear_n),
    .west_out   (west_out),
    .north_out  (north_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  int  ma [N][N];
  int  mb [N][N];
  real acc [N][N];
  real ha  [N][N];
  real va  [N][N];

  // ---------------- float helpers (integer-valued operands only) ----------
  function automatic logic [31:0] i2f(input int v);
    int          m;
    int          e;
    logic [31:0] mm;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    e = 0;
    for (int b = 0; b < 24; b++) if (m[b]) e = b;
    mm = 32'(m) << (23 - e);
    return {(v < 0), 8'(e + 127), mm[22:0]};
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real r;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(int'(x[22:0])) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    return i2f($rtoi(r));
  endfunction

  // ---------------- behavioural downstream PE array ----------------------
  always @(negedge clk) begin : pe_model
    real nh [N][N];
    real nv [N][N];
    real a_in;
    real b_in;
    if (!reset || !clear_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0.0; ha[i][j] = 0.0; va[i][j] = 0.0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) a_in = f2r(west_out[i*W +: W]);
          else        a_in = ha[i][j-1];
          if (i == 0) b_in = f2r(north_out[j*W +: W]);
          else        b_in = va[i-1][j];
          acc[i][j] = acc[i][j] + a_in * b_in;
          nh[i][j]  = a_in;
          nv[i][j]  = b_in;
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ha[i][j] = nh[i][j]; va[i][j] = nv[i][j];
        end
    end
  end

  // ---------------- checking helpers --------------------------------------
  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // packed as {load_ready, busy, clear_n, done}
  task automatic chk_ctrl(input string nm, input logic [3:0] exp);
    total++;
    if ({load_ready, busy, clear_n, done} !== exp) begin
      bad++;
      $display("FAIL %s ctrl actual=%b required=%b", nm,
               {load_ready, busy, clear_n, done}, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    load_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    load_b = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drive_beat(input int k);
    for (int i = 0; i < N; i++) begin
      load_a[i*W +: W] = i2f(ma[i][k]);
      load_b[i*W +: W] = i2f(mb[k][i]);
    end
  endtask

  task automatic rand_a();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) ma[i][k] = int'($urandom_range(0, 18)) - 9;
  endtask

  task automatic rand_b();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) mb[i][k] = int'($urandom_range(0, 18)) - 9;
  endtask

  task automatic load_all(input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          garbage();
          step();
          chk_ctrl("load_gap", 4'b1010);
        end
      end
      load_valid = 1'b1;
      drive_beat(k);
      step();
      chk_ctrl($sformatf("load_beat%0d", k), (k < N - 1) ? 4'b1010 : 4'b0010);
      load_valid = 1'b0;
      garbage();
    end
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_ctrl("clear", 4'b0100);
    chk("clear_west", west_out, '0);
    chk("clear_north", north_out, '0);
  endtask

  // Runs from CLEAR through STREAM, DONE and back to IDLE.
  task automatic stream_and_finish();
    logic [31:0]    ew [NS][N];
    logic [31:0]    eb [NS][N];
    logic [N*W-1:0] ewv;
    logic [N*W-1:0] ebv;
    int             c;
    for (int t = 0; t < NS; t++)
      for (int i = 0; i < N; i++) begin
        ew[t][i] = 32'h0; eb[t][i] = 32'h0;
      end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ew[i + k][i] = i2f(ma[i][k]);
        eb[i + k][i] = i2f(mb[k][i]);
      end
    for (int t = 0; t < NS; t++) begin
      load_valid = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      garbage();
      step();
      for (int i = 0; i < N; i++) begin
        ewv[i*W +: W] = ew[t][i];
        ebv[i*W +: W] = eb[t][i];
      end
      chk_ctrl($sformatf("stream_t%0d", t), 4'b0110);
      chk($sformatf("west_t%0d", t), west_out, ewv);
      chk($sformatf("north_t%0d", t), north_out, ebv);
    end
    load_valid = 1'b0;
    start      = 1'b0;
    step();
    chk_ctrl("done", 4'b0011);
    chk("done_west", west_out, '0);
    chk("done_north", north_out, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int k = 0; k < N; k++) c += ma[i][k] * mb[k][j];
        total++;
        if (acc[i][j] != real'(c)) begin
          bad++;
          $display("FAIL pe_acc[%0d][%0d] actual=%0f required=%0d", i, j, acc[i][j], c);
        end
      end
    step();
    chk_ctrl("back_idle", 4'b1010);
  endtask

  // ---------------- vector tables -----------------------------------------
  typedef struct {
    bit       lv;
    bit       st;
    bit [3:0] e;   // {load_ready, busy, clear_n, done} after the edge
  } vec_t;

  typedef struct {
    int          i;
    int          j;
    logic [31:0] bits;
  } res_t;

  vec_t tbl [9];
  res_t rt  [4];

  initial begin
    int beat_cnt;
    int pulses;

    // load_valid toggles; start with 2 and 3 beats is ignored; extra beat in
    // LOADED is dropped; start in LOADED enters CLEAR.
    tbl[0] = '{1'b1, 1'b0, 4'b1010};
    tbl[1] = '{1'b0, 1'b0, 4'b1010};
    tbl[2] = '{1'b1, 1'b0, 4'b1010};
    tbl[3] = '{1'b0, 1'b1, 4'b1010};
    tbl[4] = '{1'b1, 1'b0, 4'b1010};
    tbl[5] = '{1'b0, 1'b1, 4'b1010};
    tbl[6] = '{1'b1, 1'b0, 4'b0010};
    tbl[7] = '{1'b1, 1'b0, 4'b0010};
    tbl[8] = '{1'b0, 1'b1, 4'b0100};

    rt[0] = '{0, 0, 32'h41980000};
    rt[1] = '{0, 1, 32'h41B00000};
    rt[2] = '{1, 0, 32'h422C0000};
    rt[3] = '{1, 1, 32'h42480000};

    total      = 0;
    bad        = 0;
    clk        = 1'b0;
    reset      = 1'b0;
    load_valid = 1'b0;
    start      = 1'b0;
    load_a     = '0;
    load_b     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_ctrl("reset_ctrl", 4'b1010);
    chk("reset_west", west_out, '0);
    chk("reset_north", north_out, '0);
    reset = 1'b1;

    // ---- table-driven handshake, first beat right after reset release ----
    rand_a();
    rand_b();
    beat_cnt = 0;
    for (int r = 0; r < 9; r++) begin
      load_valid = tbl[r].lv;
      start      = tbl[r].st;
      if (tbl[r].lv && beat_cnt < N) begin
        drive_beat(beat_cnt);
        beat_cnt++;
      end else begin
        garbage();
      end
      step();
      chk_ctrl($sformatf("tbl_row%0d", r), tbl[r].e);
    end
    load_valid = 1'b0;
    start      = 1'b0;
    chk("tbl_clear_west", west_out, '0);
    stream_and_finish();

    // ---- back-to-back: new B, same A re-driven beat by beat ----
    rand_b();
    load_all(1'b1);
    start_pass();
    stream_and_finish();

    // ---- 2x2 product embedded in the 4x4 array ----
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = 0; mb[i][k] = 0;
      end
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    load_all(1'b0);
    start_pass();
    stream_and_finish();
    for (int r = 0; r < 4; r++)
      chk($sformatf("c2x2[%0d][%0d]", rt[r].i, rt[r].j),
          {96'h0, r2f(acc[rt[r].i][rt[r].j])}, {96'h0, rt[r].bits});

    // ---- skew check: all A = 1.0, all B = 2.0 -> every PE 8.0 ----
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ma[i][k] = 1; mb[i][k] = 2;
      end
    load_all(1'b0);
    start_pass();
    stream_and_finish();
    chk("skew_pe33", {96'h0, r2f(acc[N-1][N-1])}, {96'h0, 32'h41000000});

    // ---- reset at stream index 3 ----
    rand_a();
    rand_b();
    load_all(1'b1);
    start_pass();
    for (int t = 0; t <= 3; t++) step();
    #2 reset = 1'b0;
    #1;
    chk_ctrl("midreset_ctrl", 4'b1010);
    chk("midreset_west", west_out, '0);
    chk("midreset_north", north_out, '0);
    step();
    reset  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 3 * N; c++) begin
      step();
      if (done) pulses++;
    end
    chk("midreset_no_done", (N*W)'(pulses), '0);
    chk_ctrl("midreset_idle", 4'b1010);
    load_all(1'b0);
    start_pass();
    stream_and_finish();

    // ---- randomized passes ----
    for (int p = 0; p < 4; p++) begin
      if (p[0]) rand_a();
      rand_b();
      load_all(1'b1);
      start_pass();
      stream_and_finish();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
